ghost_motion_executor: RTL

Consumer side of the ghost-controller position interface. Each ghost controller registers a proposed `next_x`/`next_y` from the current `x`/`y`. This block accepts the proposal, checks it against bounds and `tilemap_walls`, and glides the ghost one pixel at a time toward the target. It then commits the new tile-aligned `x`/`y` back to the controller. One instance sits between each ghost controller and the renderer.

---
 rtl/ghost_motion_executor_pkg.sv | 44 ++++
 rtl/ghost_motion_executor_tile_wall_lookup.sv | 38 +++
 rtl/ghost_motion_executor.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ghost_motion_executor_pkg.sv
// ghost_motion_executor_pkg
// Shared playfield geometry, direction codes and the executor state
// encoding, imported by the motion executor and the wall lookup.
//   WIDTH/HEIGHT          : playfield size in pixels
//   tile_col_num/row_num  : playfield size in 20 px tiles
//   XW/YW                 : coordinate widths ($clog2 of WIDTH/HEIGHT)
//   WALL_BITS             : width of the flattened wall map
//   dir_t                 : glide direction codes
//   state_t               : executor FSM states
package ghost_motion_executor_pkg;

  localparam int unsigned WIDTH        = 640;
  localparam int unsigned HEIGHT       = 480;
  localparam int unsigned tile_col_num = 32;
  localparam int unsigned tile_row_num = 24;

  localparam int unsigned XW        = $clog2(WIDTH);
  localparam int unsigned YW        = $clog2(HEIGHT);
  localparam int unsigned WALL_BITS = tile_row_num * tile_col_num;

  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_t;

  typedef enum logic [1:0] {
    ST_SETTLE,
    ST_IDLE,
    ST_MOVE,
    ST_ARRIVE
  } state_t;

  // Direction of a single-axis step from its signed deltas.
  function automatic dir_t step_dir(input logic signed [XW:0] dx,
                                    input logic signed [YW:0] dy);
    if (dx != '0) begin
      return dx[XW] ? DIR_LEFT : DIR_RIGHT;
    end
    return dy[YW] ? DIR_UP : DIR_DOWN;
  endfunction

endpackage

// File: rtl/ghost_motion_executor_tile_wall_lookup.sv
// tile_wall_lookup
// Combinational map query: is a pixel position inside the playfield and,
// if so, is the tile under it a wall.
//   x, y      : pixel position (tile-aligned for a meaningful answer)
//   walls     : flattened wall map, bit row*tile_col_num + col, 1 = wall
//   in_bounds : x < WIDTH and y < HEIGHT
//   is_wall   : wall bit of the tile under (x, y); 0 when out of bounds
module tile_wall_lookup
  import ghost_motion_executor_pkg::*;
#(
  parameter int unsigned TILE = 20
) (
  input  logic [XW-1:0]        x,
  input  logic [YW-1:0]        y,
  input  logic [WALL_BITS-1:0] walls,
  output logic                 in_bounds,
  output logic                 is_wall
);

  localparam int unsigned IW = $clog2(WALL_BITS);

  logic [XW-1:0] col;
  logic [YW-1:0] row;
  logic [IW-1:0] idx;

  always_comb begin
    col       = XW'(32'(x) / TILE);
    row       = YW'(32'(y) / TILE);
    idx       = IW'(row) * IW'(tile_col_num) + IW'(col);
    in_bounds = (32'(x) < WIDTH) && (32'(y) < HEIGHT);
    is_wall   = 1'b0;
    // Out-of-range positions would index past the map; never read there.
    if (in_bounds) begin
      is_wall = walls[idx];
    end
  end

endmodule

// File: rtl/ghost_motion_executor.sv
// ghost_motion_executor
// Accepts a one-tile move proposal from a ghost controller, validates it
// against the playfield bounds and wall map, glides the drawn position one
// pixel every STEP_DIV cycles toward the target and then commits the new
// tile-aligned position back to the controller.
//   clk, reset          : clock, asynchronous active-low reset
//   next_x, next_y      : proposed target from the controller
//   tilemap_walls       : wall map, 1 = wall
//   freeze              : holds glide, sampling and all transitions
//   x, y                : committed tile-aligned position
//   draw_x, draw_y      : pixel-exact position for the renderer
//   moving              : high while gliding
//   step_done           : one-cycle pulse when a step commits
//   blocked             : one-cycle pulse when a proposal is rejected
module ghost_motion_executor
  import ghost_motion_executor_pkg::*;
#(
  parameter int unsigned TILE     = 20,
  parameter int unsigned STEP_DIV = 250000,
  parameter int unsigned START_X  = 260,
  parameter int unsigned START_Y  = 240
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [XW-1:0]        next_x,
  input  logic [YW-1:0]        next_y,
  input  logic [WALL_BITS-1:0] tilemap_walls,
  input  logic                 freeze,
  output logic [XW-1:0]        x,
  output logic [YW-1:0]        y,
  output logic [XW-1:0]        draw_x,
  output logic [YW-1:0]        draw_y,
  output logic                 moving,
  output logic                 step_done,
  output logic                 blocked
);

  localparam int unsigned DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic signed [XW:0] TILE_DX = (XW+1)'(TILE);
  localparam logic signed [YW:0] TILE_DY = (YW+1)'(TILE);

  state_t state, state_nxt;

  logic [DW-1:0] div;
  logic [XW-1:0] tgt_x;
  logic [YW-1:0] tgt_y;
  dir_t          dir;

  logic signed [XW:0] dx;
  logic signed [YW:0] dy;
  logic               zero_delta;
  logic               shape_ok;
  logic               in_bounds;
  logic               is_wall;
  logic               proposal_ok;

  logic [XW-1:0] draw_x_step;
  logic [YW-1:0] draw_y_step;
  logic          div_tc;
  logic          last_px;

  logic load_target;
  logic pix_step;
  logic commit;
  logic reject;

  tile_wall_lookup #(
    .TILE (TILE)
  ) u_lookup (
    .x         (next_x),
    .y         (next_y),
    .walls     (tilemap_walls),
    .in_bounds (in_bounds),
    .is_wall   (is_wall)
  );

  // One bit of headroom, signed, so that 0 - TILE shows up as a large
  // positive wrap rather than aliasing to -TILE.
  always_comb begin
    dx          = $signed({1'b0, next_x}) - $signed({1'b0, x});
    dy          = $signed({1'b0, next_y}) - $signed({1'b0, y});
    zero_delta  = (dx == '0) && (dy == '0);
    shape_ok    = (((dx == TILE_DX) || (dx == -TILE_DX)) && (dy == '0)) ||
                  (((dy == TILE_DY) || (dy == -TILE_DY)) && (dx == '0));
    proposal_ok = shape_ok && in_bounds && !is_wall;
  end

  always_comb begin
    draw_x_step = draw_x;
    draw_y_step = draw_y;
    case (dir)
      DIR_RIGHT: draw_x_step = draw_x + XW'(1);
      DIR_LEFT:  draw_x_step = draw_x - XW'(1);
      DIR_DOWN:  draw_y_step = draw_y + YW'(1);
      DIR_UP:    draw_y_step = draw_y - YW'(1);
      default:   ;
    endcase
    div_tc  = (div == DW'(STEP_DIV - 1));
    last_px = (draw_x_step == tgt_x) && (draw_y_step == tgt_y);
  end

  // Next-state and control strobes. Everything is gated by freeze so the
  // machine, divider and pulses all hold together.
  always_comb begin
    state_nxt   = state;
    load_target = 1'b0;
    pix_step    = 1'b0;
    commit      = 1'b0;
    reject      = 1'b0;
    if (!freeze) begin
      case (state)
        ST_SETTLE: state_nxt = ST_IDLE;
        ST_IDLE: begin
          if (!zero_delta) begin
            if (proposal_ok) begin
              state_nxt   = ST_MOVE;
              load_target = 1'b1;
            end else begin
              state_nxt = ST_SETTLE;
              reject    = 1'b1;
            end
          end
        end
        ST_MOVE: begin
          if (div_tc) begin
            pix_step = 1'b1;
            // Leave on the edge that lands the final pixel so the glide
            // occupies exactly TILE*STEP_DIV cycles.
            if (last_px) begin
              state_nxt = ST_ARRIVE;
            end
          end
        end
        ST_ARRIVE: begin
          state_nxt = ST_SETTLE;
          commit    = 1'b1;
        end
        default: state_nxt = ST_SETTLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_SETTLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x         <= XW'(START_X);
      y         <= YW'(START_Y);
      draw_x    <= XW'(START_X);
      draw_y    <= YW'(START_Y);
      tgt_x     <= XW'(START_X);
      tgt_y     <= YW'(START_Y);
      dir       <= DIR_RIGHT;
      div       <= '0;
      step_done <= 1'b0;
      blocked   <= 1'b0;
    end else begin
      step_done <= commit;
      blocked   <= reject;
      if (load_target) begin
        tgt_x <= next_x;
        tgt_y <= next_y;
        dir   <= step_dir(dx, dy);
        div   <= '0;
      end else if ((state == ST_MOVE) && !freeze) begin
        div <= div_tc ? '0 : div + DW'(1);
      end
      if (pix_step) begin
        draw_x <= draw_x_step;
        draw_y <= draw_y_step;
      end
      if (commit) begin
        x <= tgt_x;
        y <= tgt_y;
      end
    end
  end

  assign moving = (state == ST_MOVE);

endmodule
